// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two writeback requesters, the register file write/read
// ports and the arbiter. The slave modport is the arbiter's view; master is the
// surrounding datapath's view.
interface regfile_wb_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
);
   logic                  req0_valid;
   logic [ADDR_WIDTH-1:0] req0_reg;
   logic [DATA_WIDTH-1:0] req0_data;
   logic                  req0_ready;
   logic                  req1_valid;
   logic [ADDR_WIDTH-1:0] req1_reg;
   logic [DATA_WIDTH-1:0] req1_data;
   logic                  req1_ready;
   logic                  ctrl_writeEnable;
   logic [ADDR_WIDTH-1:0] ctrl_writeReg;
   logic [DATA_WIDTH-1:0] data_writeReg;
   logic [ADDR_WIDTH-1:0] ctrl_readRegA;
   logic [ADDR_WIDTH-1:0] ctrl_readRegB;
   logic [DATA_WIDTH-1:0] rf_readRegA;
   logic [DATA_WIDTH-1:0] rf_readRegB;
   logic [DATA_WIDTH-1:0] data_readRegA;
   logic [DATA_WIDTH-1:0] data_readRegB;
   logic [CNT_WIDTH-1:0]  wb_count;

   modport slave (
      input  req0_valid, req0_reg, req0_data,
      output req0_ready,
      input  req1_valid, req1_reg, req1_data,
      output req1_ready,
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      input  ctrl_readRegA, ctrl_readRegB, rf_readRegA, rf_readRegB,
      output data_readRegA, data_readRegB,
      output wb_count
   );

   modport master (
      output req0_valid, req0_reg, req0_data,
      input  req0_ready,
      output req1_valid, req1_reg, req1_data,
      input  req1_ready,
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      output ctrl_readRegA, ctrl_readRegB, rf_readRegA, rf_readRegB,
      input  data_readRegA, data_readRegB,
      input  wb_count
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter in front of a register file write port.
// Round-robin on contention (prio bit flips to the loser), single-cycle
// registered write stage, register 0 writes swallowed, saturating count of
// committed writes.
// Optional macro WB_BYPASS_EN: forwards the in-flight write data onto the read
// ports when the read index matches the register being written this cycle.
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
) (
   input logic                 clock,
   input logic                 ctrl_reset_n,
   regfile_wb_arbiter_if.slave bus
);

   logic                  r_prio;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_wreg;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [CNT_WIDTH-1:0]  r_cnt;

   logic                  w_both;
   logic                  w_gnt0;
   logic                  w_gnt1;
   logic [ADDR_WIDTH-1:0] w_sel_reg;
   logic [DATA_WIDTH-1:0] w_sel_data;

   // Grant decode; readies are held low while reset is asserted
   always_comb begin
      w_both     = bus.req0_valid & bus.req1_valid;
      w_gnt0     = ctrl_reset_n & bus.req0_valid & (~bus.req1_valid | ~r_prio);
      w_gnt1     = ctrl_reset_n & bus.req1_valid & (~bus.req0_valid | r_prio);
      w_sel_reg  = w_gnt1 ? bus.req1_reg  : bus.req0_reg;
      w_sel_data = w_gnt1 ? bus.req1_data : bus.req0_data;
   end

   assign bus.req0_ready = w_gnt0;
   assign bus.req1_ready = w_gnt1;

   // Priority pointer moves to the loser only when both requesters contend
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         r_prio <= 1'b0;
      end else if (w_both) begin
         r_prio <= ~r_prio;
      end
   end

   // Write stage: capture granted request; register 0 is accepted but not written
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         r_we    <= 1'b0;
         r_wreg  <= '0;
         r_wdata <= '0;
      end else if (w_gnt0 | w_gnt1) begin
         r_we    <= (w_sel_reg != '0);
         r_wreg  <= w_sel_reg;
         r_wdata <= w_sel_data;
      end else begin
         r_we    <= 1'b0;
      end
   end

   // Committed-write counter, counts each strobed cycle and sticks at all-ones
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         r_cnt <= '0;
      end else if (r_we && (r_cnt != {CNT_WIDTH{1'b1}})) begin
         r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign bus.ctrl_writeEnable = r_we;
   assign bus.ctrl_writeReg    = r_wreg;
   assign bus.data_writeReg    = r_wdata;
   assign bus.wb_count         = r_cnt;

`ifdef WB_BYPASS_EN
   // Forward the write in flight so a same-cycle read sees the new value
   always_comb begin
      bus.data_readRegA = (r_we && (r_wreg == bus.ctrl_readRegA)) ? r_wdata : bus.rf_readRegA;
      bus.data_readRegB = (r_we && (r_wreg == bus.ctrl_readRegB)) ? r_wdata : bus.rf_readRegB;
   end
`else
   assign bus.data_readRegA = bus.rf_readRegA;
   assign bus.data_readRegB = bus.rf_readRegB;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 32, write/read data width
- ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 16, width of the committed-write counter
REQ-002 Ports SHALL be:
- clock  in  1  single clock, all state on rising edge
- ctrl_reset_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 (ALU writeback) has a write
- req0_reg  in  ADDR_WIDTH  requester 0 destination register
- req0_data  in  DATA_WIDTH  requester 0 write data
- req0_ready  out  1  requester 0 write accepted this cycle
- req1_valid  in  1  requester 1 (load writeback) has a write
- req1_reg  in  ADDR_WIDTH  requester 1 destination register
- req1_data  in  DATA_WIDTH  requester 1 write data
- req1_ready  out  1  requester 1 write accepted this cycle
- ctrl_writeEnable  out  1  registered write strobe to register file
- ctrl_writeReg  out  ADDR_WIDTH  registered write index to register file
- data_writeReg  out  DATA_WIDTH  registered write data to register file
- ctrl_readRegA  in  ADDR_WIDTH  read port A index (shared with register file)
- ctrl_readRegB  in  ADDR_WIDTH  read port B index (shared with register file)
- rf_readRegA  in  DATA_WIDTH  register file port A data
- rf_readRegB  in  DATA_WIDTH  register file port B data
- data_readRegA  out  DATA_WIDTH  port A data to datapath
- data_readRegB  out  DATA_WIDTH  port B data to datapath
- wb_count  out  CNT_WIDTH  committed non-zero-register writes, saturating
REQ-003 One clock; reset asynchronous, active-low (ctrl_reset_n).

Function
REQ-004 Acceptance: one grant per cycle max; a transfer occurs when reqN_valid and reqN_ready are both high at a rising edge.
REQ-005 reqN_ready SHALL be combinational from valids and priority pointer; never asserted without its own valid.
REQ-006 Grant rule: only one valid -> grant it; both valid -> grant requester named by prio; none -> no grant.
REQ-007 prio (1 bit) SHALL update only on a both-valid cycle, to the non-granted requester; single-requester grants leave prio unchanged.
REQ-008 Output stage: on a grant, next edge loads ctrl_writeReg/data_writeReg from granted requester; latency exactly 1 cycle.
REQ-009 ctrl_writeEnable SHALL be high for exactly the cycle after a grant whose reg is non-zero; grants to register 0 are accepted (ready high) but produce ctrl_writeEnable=0.
REQ-010 With no grant, ctrl_writeEnable SHALL be 0 next cycle; ctrl_writeReg/data_writeReg hold last values.
REQ-011 Back-to-back grants SHALL yield back-to-back writes, no bubble.
REQ-012 Both requesters targeting the same register in one cycle: normal arbitration; loser's write lands one cycle after winner's (later write wins in file).
REQ-013 wb_count SHALL increment by 1 on every cycle ctrl_writeEnable is high, saturating at all-ones (no wrap).
REQ-014 Non-granted requester SHALL hold valid/reg/data stable until accepted; block does not buffer unaccepted requests.

Reset
REQ-015 ctrl_reset_n low SHALL immediately force: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, prio=0, wb_count=0; req0_ready/req1_ready SHALL be 0 while reset asserted.
REQ-016 A grant in the cycle reset asserts SHALL be discarded; no write issues after reset release without a new grant.

Configuration
REQ-017 Macro WB_BYPASS_EN: defined -> data_readRegX = data_writeReg when ctrl_writeEnable=1 and ctrl_writeReg==ctrl_readRegX (X=A,B), else rf_readRegX; covers the register file's in-flight-write read.
REQ-018 WB_BYPASS_EN undefined -> data_readRegX = rf_readRegX unconditionally; no bypass logic synthesized.

Verification
REQ-019 Reset, then req0 only: reg=3, data=0x11 -> req0_ready=1 same cycle; next cycle WE=1, writeReg=3, data=0x11; wb_count=1.
REQ-020 Both valid 4 cycles, reg0=1/data=0xA, reg1=2/data=0xB, prio=0 -> grants 0,1,0,1; writes alternate 1,2,1,2 consecutive cycles.
REQ-021 req1 only, reg=0, data=0xFF -> req1_ready=1, WE stays 0, wb_count unchanged.
REQ-022 Both valid same reg=5, data 0x1/0x2 -> two writes to 5 on consecutive cycles, order per prio; final value from later write.
REQ-023 ctrl_reset_n low mid-stream with WE=1 -> WE=0, wb_count=0, prio=0 without clock edge; no write after release until new valid.
REQ-024 WB_BYPASS_EN defined, WE=1 writeReg=7 data=0x55, readRegA=7, rf_readRegA=Z -> data_readRegA=0x55; undefined -> data_readRegA=Z.
